ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 196 +++++++++++++++++++
 tb/tb_ex_mem_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch resolution and an overflow-trap FSM (RUN/TRAP).
// Optional performance counters are compiled in when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] pc,
  input  logic              alu_zero,
  input  logic              alu_ge_than_zero,
  input  logic              alu_overflow,
  input  logic [2:0]        branch_type,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              trap_ovf,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [4:0]        dest_reg,
  input  logic              exc_ack,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_br_taken,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [4:0]        out_dest_reg,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc,
  output logic              exc_req,
  output logic [DATA_W-1:0] exc_epc
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic [4:0]          dst_q, dst_d;
  logic                rw_q, rw_d;
  logic                mr_q, mr_d;
  logic                mw_q, mw_d;
  logic                bt_q, bt_d;
  logic [DATA_W-1:0]   bpc_q, bpc_d;
  logic                exc_q, exc_d;
  logic [DATA_W-1:0]   epc_q, epc_d;

  logic accept;
  logic trap_hit;
  logic br_hit;

  function automatic logic branch_cond(input logic [2:0] ty, input logic z, input logic ge);
    case (ty)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return ge;
      3'd4:    return !ge;
      3'd5:    return ge & !z;
      3'd6:    return !ge | z;
      default: return 1'b0;
    endcase
  endfunction

  assign br_hit   = branch_cond(branch_type, alu_zero, alu_ge_than_zero);
  assign accept   = (state_q == RUN) & in_valid & ~stall & ~flush;
  assign trap_hit = accept & alu_overflow & trap_ovf;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    res_d   = res_q;
    store_d = store_q;
    dst_d   = dst_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    bt_d    = bt_q;
    bpc_d   = bpc_q;
    exc_d   = exc_q;
    epc_d   = epc_q;

    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      bt_d    = 1'b0;
    end else if (!stall && state_q == RUN) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      bt_d    = 1'b0;
      if (trap_hit) begin
        // Overflowing instruction is squashed; only its PC survives.
        state_d = TRAP;
        exc_d   = 1'b1;
        epc_d   = pc;
      end else if (in_valid) begin
        valid_d = 1'b1;
        res_d   = alu_out;
        store_d = rt_data;
        dst_d   = dest_reg;
        rw_d    = reg_write;
        mr_d    = mem_read;
        mw_d    = mem_write;
        if (br_hit) begin
          bt_d  = 1'b1;
          bpc_d = branch_target;
        end
      end
    end

    // Flush cannot leave TRAP by itself, but it does not block an acknowledge either.
    if (state_q == TRAP && exc_ack && (flush || !stall)) begin
      state_d = RUN;
      exc_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      res_q   <= '0;
      store_q <= '0;
      dst_q   <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      bt_q    <= 1'b0;
      bpc_q   <= '0;
      exc_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      store_q <= store_d;
      dst_q   <= dst_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      bt_q    <= bt_d;
      bpc_q   <= bpc_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_result = res_q;
  assign out_rt_data    = store_q;
  assign out_dest_reg   = dst_q;
  assign out_reg_write  = valid_q & rw_q;
  assign out_mem_read   = valid_q & mr_q;
  assign out_mem_write  = valid_q & mw_q;
  assign branch_taken   = bt_q;
  assign branch_pc      = bpc_q;
  assign exc_req        = exc_q;
  assign exc_epc        = epc_q;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_ret_q, perf_ret_d;
  logic [31:0] perf_brc_q, perf_brc_d;
  logic        retire;

  // Stall and flush both drop accept, so the counters hold under either.
  assign retire     = accept & ~trap_hit;
  assign perf_ret_d = perf_ret_q + 32'(retire);
  assign perf_brc_d = perf_brc_q + 32'(retire & br_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ret_q <= '0;
      perf_brc_q <= '0;
    end else begin
      perf_ret_q <= perf_ret_d;
      perf_brc_q <= perf_brc_d;
    end
  end

  assign perf_retired  = perf_ret_q;
  assign perf_br_taken = perf_brc_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg plus hand-written stall, trap and reset sequences.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [31:0] alu_out, rt_data, pc, branch_target;
  logic        alu_zero, alu_ge_than_zero, alu_overflow;
  logic [2:0]  branch_type;
  logic        trap_ovf, reg_write, mem_read, mem_write, exc_ack;
  logic [4:0]  dest_reg;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] out_alu_result, out_rt_data, branch_pc, exc_epc;
  logic [4:0]  out_dest_reg;
  logic        branch_taken, exc_req;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_retired, perf_br_taken;
`endif

  ex_mem_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_out(alu_out), .rt_data(rt_data), .pc(pc),
    .alu_zero(alu_zero), .alu_ge_than_zero(alu_ge_than_zero), .alu_overflow(alu_overflow),
    .branch_type(branch_type), .branch_target(branch_target),
    .trap_ovf(trap_ovf), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .dest_reg(dest_reg), .exc_ack(exc_ack),
`ifdef EX_MEM_PERF_CNT_EN
    .perf_retired(perf_retired), .perf_br_taken(perf_br_taken),
`endif
    .out_valid(out_valid), .out_alu_result(out_alu_result), .out_rt_data(out_rt_data),
    .out_dest_reg(out_dest_reg), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .exc_req(exc_req), .exc_epc(exc_epc)
  );

  always #5 clk = ~clk;

  // ctl {in_valid,stall,flush,exc_ack}; flg {zero,ge,ovf,trap_ovf}; we {rw,mr,mw}
  // ectl {out_valid,out_reg_write,out_mem_read,out_mem_write,branch_taken,exc_req}
  typedef struct {
    logic [3:0]  ctl;
    logic [3:0]  flg;
    logic [2:0]  we;
    logic [2:0]  bty;
    logic [4:0]  dst;
    logic [31:0] alu, rt, pc, btg;
    logic [5:0]  ectl;
    logic [31:0] ealu, ert;
    logic [4:0]  edst;
    logic [31:0] ebpc, eepc;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];
  vec_t h;
  int checks = 0;
  int errors = 0;
  logic [5:0] octl;

  assign octl = {out_valid, out_reg_write, out_mem_read, out_mem_write, branch_taken, exc_req};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.ctl[3]; stall = v.ctl[2]; flush = v.ctl[1]; exc_ack = v.ctl[0];
    alu_zero = v.flg[3]; alu_ge_than_zero = v.flg[2]; alu_overflow = v.flg[1]; trap_ovf = v.flg[0];
    reg_write = v.we[2]; mem_read = v.we[1]; mem_write = v.we[0];
    branch_type = v.bty; dest_reg = v.dst;
    alu_out = v.alu; rt_data = v.rt; pc = v.pc; branch_target = v.btg;
  endtask

  task automatic check_outs(input string nm, input vec_t v);
    chk({nm, " ctl"}, 32'(octl), 32'(v.ectl));
    chk({nm, " alu"}, out_alu_result, v.ealu);
    chk({nm, " rt"}, out_rt_data, v.ert);
    chk({nm, " dst"}, 32'(out_dest_reg), 32'(v.edst));
    chk({nm, " bpc"}, branch_pc, v.ebpc);
    chk({nm, " epc"}, exc_epc, v.eepc);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    check_outs(nm, v);
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 4'b0000, 3'b100, 3'd0, 5'd5, 32'h2, 32'h7, 32'h4, 32'h0,
                 6'b110000, 32'h2, 32'h7, 5'd5, 32'h0, 32'h0};
    vecs[1]  = '{4'b1000, 4'b1000, 3'b000, 3'd1, 5'd0, 32'h0, 32'h0, 32'h8, 32'h400,
                 6'b100010, 32'h0, 32'h0, 5'd0, 32'h400, 32'h0};
    vecs[2]  = '{4'b0000, 4'b0000, 3'b000, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0,
                 6'b000000, 32'h0, 32'h0, 5'd0, 32'h400, 32'h0};
    vecs[3]  = '{4'b1000, 4'b0000, 3'b000, 3'd1, 5'd0, 32'h11, 32'h0, 32'hC, 32'h800,
                 6'b100000, 32'h11, 32'h0, 5'd0, 32'h400, 32'h0};
    vecs[4]  = '{4'b1000, 4'b1100, 3'b000, 3'd5, 5'd0, 32'h12, 32'h0, 32'h10, 32'h500,
                 6'b100000, 32'h12, 32'h0, 5'd0, 32'h400, 32'h0};
    vecs[5]  = '{4'b1000, 4'b0000, 3'b000, 3'd4, 5'd0, 32'h13, 32'h0, 32'h14, 32'h600,
                 6'b100010, 32'h13, 32'h0, 5'd0, 32'h600, 32'h0};
    vecs[6]  = '{4'b1000, 4'b0000, 3'b001, 3'd2, 5'd3, 32'h14, 32'hDEAD, 32'h18, 32'h700,
                 6'b100110, 32'h14, 32'hDEAD, 5'd3, 32'h700, 32'h0};
    vecs[7]  = '{4'b1000, 4'b0100, 3'b010, 3'd6, 5'd9, 32'h15, 32'h1, 32'h1C, 32'h900,
                 6'b101000, 32'h15, 32'h1, 5'd9, 32'h700, 32'h0};
    vecs[8]  = '{4'b1000, 4'b1100, 3'b100, 3'd7, 5'd1, 32'h16, 32'h2, 32'h20, 32'hB00,
                 6'b110000, 32'h16, 32'h2, 5'd1, 32'h700, 32'h0};
    vecs[9]  = '{4'b1000, 4'b0010, 3'b100, 3'd0, 5'd4, 32'h7FFFFFFF, 32'h3, 32'h24, 32'h0,
                 6'b110000, 32'h7FFFFFFF, 32'h3, 5'd4, 32'h700, 32'h0};
    vecs[10] = '{4'b1001, 4'b0100, 3'b000, 3'd3, 5'd0, 32'h17, 32'h0, 32'h28, 32'hA00,
                 6'b100010, 32'h17, 32'h0, 5'd0, 32'hA00, 32'h0};
    vecs[11] = '{4'b1110, 4'b1000, 3'b100, 3'd1, 5'd8, 32'h99, 32'h5, 32'h2C, 32'hC00,
                 6'b000000, 32'h17, 32'h0, 5'd0, 32'hA00, 32'h0};

    h = '{4'b0000, 4'b0000, 3'b000, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0,
          6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0};
    drive(h);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outs("reset", h);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stall freezes everything while inputs churn; stall+flush then clears valid.
    h = '{4'b1000, 4'b0000, 3'b100, 3'd0, 5'd6, 32'h55, 32'h9, 32'h30, 32'h0,
          6'b110000, 32'h55, 32'h9, 5'd6, 32'hA00, 32'h0};
    run_vec("stall_load", h);
    for (int k = 0; k < 3; k++) begin
      h.ctl = 4'b1100; h.flg = 4'b1000; h.bty = 3'd1; h.btg = 32'hF00;
      h.alu = 32'h60 + 32'(k); h.dst = 5'(k); h.rt = 32'h70 + 32'(k);
      run_vec($sformatf("stall%0d", k), h);
    end
    h.ctl = 4'b1110; h.ectl = 6'b000000;
    run_vec("stall_flush", h);

    // Overflow trap: squash, latch EPC, ignore inputs and flush until acknowledged.
    h = '{4'b1000, 4'b0011, 3'b100, 3'd0, 5'd2, 32'h80000000, 32'h0, 32'h1C, 32'h0,
          6'b000001, 32'h55, 32'h9, 5'd6, 32'hA00, 32'h1C};
    run_vec("trap_enter", h);
    for (int k = 0; k < 2; k++) begin
      h.flg = 4'b1000; h.bty = 3'd1; h.btg = 32'h123; h.alu = 32'h1; h.pc = 32'h40 + 32'(4 * k);
      run_vec($sformatf("trap_drop%0d", k), h);
    end
    h.ctl = 4'b1010;
    run_vec("trap_flush", h);
    h.ctl = 4'b1001; h.ectl = 6'b000000;
    run_vec("trap_ack", h);
    h = '{4'b1000, 4'b0000, 3'b100, 3'd0, 5'd7, 32'h21, 32'h0, 32'h44, 32'h0,
          6'b110000, 32'h21, 32'h0, 5'd7, 32'hA00, 32'h1C};
    run_vec("after_ack", h);

    // Asynchronous reset in the middle of a trap, then accept on the first edge.
    h = '{4'b1000, 4'b0011, 3'b000, 3'd0, 5'd0, 32'h1, 32'h0, 32'h30, 32'h0,
          6'b000001, 32'h21, 32'h0, 5'd7, 32'hA00, 32'h30};
    run_vec("trap2_enter", h);
    h = '{4'b0000, 4'b0000, 3'b000, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0,
          6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0};
    drive(h);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", h);
`ifdef EX_MEM_PERF_CNT_EN
    chk("async_rst perf_ret", perf_retired, 32'h0);
    chk("async_rst perf_br", perf_br_taken, 32'h0);
`endif
    #1 rst = 1'b0;
    h = '{4'b1000, 4'b0000, 3'b100, 3'd0, 5'd3, 32'h42, 32'h0, 32'h50, 32'h0,
          6'b110000, 32'h42, 32'h0, 5'd3, 32'h0, 32'h0};
    run_vec("first_after_rst", h);

`ifdef EX_MEM_PERF_CNT_EN
    dut.perf_ret_q = 32'hFFFFFFFF;
    h.alu = 32'h43;
    h.ealu = 32'h43;
    run_vec("perf_wrap_vec", h);
    chk("perf_wrap", perf_retired, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
